pulse_stretch_q: RTL and testbench

Pulse-to-level regenerator: the receiving end of the single-cycle event pulses our edge detectors produce on the cursor-control path. Each accepted input pulse becomes one high window of fixed length on level_out. Consecutive windows are separated by a guaranteed low gap. Pulses that arrive while a window or gap is in progress are queued in a saturating pending counter, so downstream level-sensitive logic (cursor stepper, LED/debug indicators) sees every event as a distinct level.

---
 rtl/pulse_stretch_q.sv | 144 ++++++++++++++
 tb/tb_pulse_stretch_q.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretch_q.sv
// pulse_stretch_q: turns single-cycle event strobes into fixed-length high
// windows on level_out. Consecutive windows are separated by a guaranteed
// low gap. Events that arrive while a window or gap is running are held in
// a saturating pending counter. An event that arrives while the counter is
// already full is dropped, and the sticky overflow flag is set.
//
// Optional build macro PULSE_STRETCH_MERGE_EN: when it is defined, a pulse
// during a high window restarts that window instead of being queued.
module pulse_stretch_q #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int QUEUE_DEPTH = 7
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             pulse_in,
    input  logic                             clr,
    output logic                             level_out,
    output logic                             busy,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] pending,
    output logic                             overflow
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int PEND_W  = $clog2(QUEUE_DEPTH + 1);

    localparam logic [CNT_W-1:0]  HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] Q_MAX   = PEND_W'(QUEUE_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              pend_inc;
    logic              pend_dec;
    logic [PEND_W-1:0] pend_nxt;
    logic              ovf_nxt;

    // Window/gap sequencing: next state, counter reload, and queue requests
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_inc  = 1'b0;
        pend_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pulse_in) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = HOLD_LD;
                end
            end
            ST_HIGH: begin
                if (cnt == '0) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = GAP_LD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
`ifdef PULSE_STRETCH_MERGE_EN
                // A pulse during the window restarts it and is not queued
                if (pulse_in) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = HOLD_LD;
                end
`else
                pend_inc = pulse_in;
`endif
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    if (pending != '0) begin
                        // Queued event goes first; a pulse this cycle takes its slot
                        state_nxt = ST_HIGH;
                        cnt_nxt   = HOLD_LD;
                        pend_dec  = 1'b1;
                        pend_inc  = pulse_in;
                    end else if (pulse_in) begin
                        state_nxt = ST_HIGH;
                        cnt_nxt   = HOLD_LD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt  = cnt - CNT_W'(1);
                    pend_inc = pulse_in;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Saturating pending counter; a drop on a full queue raises overflow
    always_comb begin
        pend_nxt = pending;
        ovf_nxt  = overflow;
        if (pend_inc && !pend_dec) begin
            if (pending == Q_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                pend_nxt = pending + PEND_W'(1);
            end
        end else if (pend_dec && !pend_inc) begin
            pend_nxt = pending - PEND_W'(1);
        end
    end

    // State registers; clr wipes everything and ignores the same-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pending   <= '0;
            overflow  <= 1'b0;
            level_out <= 1'b0;
        end else if (clr) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pending   <= '0;
            overflow  <= 1'b0;
            level_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pending   <= pend_nxt;
            overflow  <= ovf_nxt;
            level_out <= (state_nxt == ST_HIGH);
        end
    end

    // Busy is derived only from registers, so pulse_in cannot glitch it
    always_comb begin
        busy = (state != ST_IDLE) || (pending != '0);
    end

endmodule

// File: tb/tb_pulse_stretch_q.sv
// tb_pulse_stretch_q: directed scenarios for pulse_stretch_q with default
// parameters. Expected output snapshots are queued up front. Each snapshot is
// keyed by the number of rising edges since reset was released. A monitor
// pops and compares a snapshot shortly after the matching edge. A snapshot
// keyed 0 is compared when reset is asserted.
module tb_pulse_stretch_q;

    logic       clk;
    logic       rst_n;
    logic       pulse_in;
    logic       clr;
    logic       level_out;
    logic       busy;
    logic [2:0] pending;
    logic       overflow;

    pulse_stretch_q #(
        .HOLD_CYCLES(4),
        .GAP_CYCLES (2),
        .QUEUE_DEPTH(7)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pulse_in (pulse_in),
        .clr      (clr),
        .level_out(level_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    typedef struct {
        int         cyc;
        logic       lvl;
        logic       bsy;
        logic [2:0] pnd;
        logic       ovf;
        int         scn;
    } exp_t;

    exp_t         q[$];
    int           vectors     = 0;
    int           miscompares = 0;
    int           cyc         = 0;
    int           scn         = 0;
    logic [127:0] pm;
    logic [127:0] cm;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: cycle n is the nth rising edge after reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monitor: compare every snapshot whose cycle has just been reached
    always begin
        exp_t e;
        @(posedge clk or negedge rst_n);
        #1;
        while (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            vectors++;
            if (level_out !== e.lvl || busy !== e.bsy || pending !== e.pnd || overflow !== e.ovf) begin
                miscompares++;
                $display("FAIL s%0d@c%0d: got lvl=%0b busy=%0b pend=%0d ovf=%0b, want lvl=%0b busy=%0b pend=%0d ovf=%0b",
                         e.scn, e.cyc, level_out, busy, pending, overflow, e.lvl, e.bsy, e.pnd, e.ovf);
            end
        end
        if (q.size() > 0 && q[0].cyc != 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL s%0d@c%0d: snapshot missed, now at c%0d", e.scn, e.cyc, cyc);
        end
    end

    task automatic chk(input int c, input logic l, input logic b, input int p, input logic o);
        exp_t e;
        e.cyc = c;
        e.lvl = l;
        e.bsy = b;
        e.pnd = 3'(p);
        e.ovf = o;
        e.scn = scn;
        q.push_back(e);
    endtask

    // Apply reset with a reset-state snapshot, then clear the stimulus masks
    task automatic begin_scn(input int id);
        pulse_in = 1'b0;
        clr      = 1'b0;
        pm       = '0;
        cm       = '0;
        @(negedge clk);
        scn = id;
        chk(0, 1'b0, 1'b0, 0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive edges 1..n from the masks; inputs change on falling edges
    task automatic run(input int n);
        for (int e = 1; e <= n; e++) begin
            pulse_in = pm[e];
            clr      = cm[e];
            @(negedge clk);
        end
        pulse_in = 1'b0;
        clr      = 1'b0;
    endtask

    // Every snapshot of the scenario must have been consumed by now
    task automatic end_scn();
        while (q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL s%0d@c%0d: snapshot never reached", q[0].scn, q[0].cyc);
            void'(q.pop_front());
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        pulse_in = 1'b0;
        clr      = 1'b0;
        pm       = '0;
        cm       = '0;

        // 1: single pulse -> four-cycle window, two-cycle gap, idle
        begin_scn(1);
        pm[10] = 1'b1;
        chk(9,  0, 0, 0, 0);
        chk(10, 1, 1, 0, 0);
        chk(13, 1, 1, 0, 0);
        chk(14, 0, 1, 0, 0);
        chk(15, 0, 1, 0, 0);
        chk(16, 0, 0, 0, 0);
        chk(17, 0, 0, 0, 0);
        run(18);
        end_scn();

        // 2: three back-to-back pulses -> three separated windows
        begin_scn(2);
        pm[10] = 1'b1; pm[11] = 1'b1; pm[12] = 1'b1;
        chk(10, 1, 1, 0, 0);
        chk(11, 1, 1, 1, 0);
        chk(12, 1, 1, 2, 0);
        chk(14, 0, 1, 2, 0);
        chk(15, 0, 1, 2, 0);
        chk(16, 1, 1, 1, 0);
        chk(19, 1, 1, 1, 0);
        chk(20, 0, 1, 1, 0);
        chk(21, 0, 1, 1, 0);
        chk(22, 1, 1, 0, 0);
        chk(25, 1, 1, 0, 0);
        chk(26, 0, 1, 0, 0);
        chk(27, 0, 1, 0, 0);
        chk(28, 0, 0, 0, 0);
        run(29);
        end_scn();

        // 3: held pulse fills the queue, overflow sticks through drain until clr
        begin_scn(3);
        for (int e = 10; e <= 19; e++) pm[e] = 1'b1;
        cm[66] = 1'b1;
        chk(18, 1, 1, 7, 0);
        chk(19, 1, 1, 7, 1);
        chk(20, 0, 1, 7, 1);
        chk(21, 0, 1, 7, 1);
        chk(22, 1, 1, 6, 1);
        chk(28, 1, 1, 5, 1);
        chk(58, 1, 1, 0, 1);
        chk(63, 0, 1, 0, 1);
        chk(64, 0, 0, 0, 1);
        chk(66, 0, 0, 0, 0);
        run(67);
        end_scn();

        // 4: pulse on gap exit with a full queue -> pending held, no overflow
        begin_scn(4);
        for (int e = 10; e <= 15; e++) pm[e] = 1'b1;
        pm[17] = 1'b1; pm[18] = 1'b1; pm[19] = 1'b1; pm[22] = 1'b1;
        chk(15, 0, 1, 5, 0);
        chk(16, 1, 1, 4, 0);
        chk(19, 1, 1, 7, 0);
        chk(20, 0, 1, 7, 0);
        chk(21, 0, 1, 7, 0);
        chk(22, 1, 1, 7, 0);
        chk(23, 1, 1, 7, 0);
        run(24);
        end_scn();

        // 5: pulse on gap exit with an empty queue -> no idle cycle between windows
        begin_scn(5);
        pm[10] = 1'b1; pm[16] = 1'b1;
        chk(14, 0, 1, 0, 0);
        chk(15, 0, 1, 0, 0);
        chk(16, 1, 1, 0, 0);
        chk(19, 1, 1, 0, 0);
        chk(20, 0, 1, 0, 0);
        run(21);
        end_scn();

        // 6: asynchronous reset inside a window with three events queued
        begin_scn(6);
        pm[8] = 1'b1; pm[9] = 1'b1; pm[10] = 1'b1; pm[11] = 1'b1;
        chk(8,  1, 1, 0, 0);
        chk(11, 1, 1, 3, 0);
        run(11);
        chk(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        end_scn();

        // 7: synchronous clear at the same point; pulse in the clr cycle ignored
        begin_scn(7);
        pm[8] = 1'b1; pm[9] = 1'b1; pm[10] = 1'b1; pm[11] = 1'b1; pm[12] = 1'b1;
        cm[12] = 1'b1;
        chk(11, 1, 1, 3, 0);
        chk(12, 0, 0, 0, 0);
        chk(13, 0, 0, 0, 0);
        run(14);
        end_scn();

        // 8: pulse during a window -> restart with merge, queued without
        begin_scn(8);
        pm[10] = 1'b1; pm[13] = 1'b1;
`ifdef PULSE_STRETCH_MERGE_EN
        chk(10, 1, 1, 0, 0);
        chk(13, 1, 1, 0, 0);
        chk(16, 1, 1, 0, 0);
        chk(17, 0, 1, 0, 0);
        chk(19, 0, 0, 0, 0);
`else
        chk(13, 1, 1, 1, 0);
        chk(14, 0, 1, 1, 0);
        chk(16, 1, 1, 0, 0);
        chk(19, 1, 1, 0, 0);
        chk(20, 0, 1, 0, 0);
        chk(22, 0, 0, 0, 0);
`endif
        run(23);
        end_scn();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d snapshots pending", q.size());
        $fatal(1, "time limit");
    end

endmodule
